recovery_sequencer: RTL and testbench
=====================================

// Module: recovery_sequencer
// PURPOSE
//  Checkpoint/rollback controller for the TMR core. It sequences the Recovery_Register bank:
//  - on a checkpoint request, copies architectural regs x1..x31 and the PC into the bank;
//  - on a voter-mismatch recovery request, restores them into the main register file and reloads the PC.
//  - Stalls the core while it owns both register files. Counts consecutive rollbacks and declares fatal.
// PARAMETERS
//  NUM_REGS   32  architectural registers; x0 never copied or restored
//  MAX_RETRY  3   rollbacks allowed without an intervening checkpoint; the next one is fatal
// PORTS
//  clk         in   1   single clock; all state on posedge clk
//  rst         in   1   asynchronous, active-high reset
//  ckpt_req    in   1   level; request checkpoint (sampled in IDLE only)
//  rec_req     in   1   level; TMR mismatch, request rollback (sampled in IDLE and CKPT)
//  core_pc     in   32  committed PC captured at checkpoint accept
//  stall       out  1   freeze core pipeline; equals busy
//  busy        out  1   high in every state except IDLE
//  rf_addr     out  5   main RF address (read in CKPT, write in REST)
//  rf_rd       in   32  main RF combinational read data
//  rf_we       out  1   main RF write enable
//  rf_wd       out  32  main RF write data (= rr_RD)
//  rr_A        out  32  recovery bank address, zero-extended index
//  rr_WE       out  1   recovery bank write enable
//  rr_WD       out  32  recovery bank write data (= rf_rd)
//  rr_RD       in   32  recovery bank combinational read data
//  pc_load     out  1   one-cycle pulse: core loads restore_pc
//  restore_pc  out  32  PC saved at last completed checkpoint
//  ckpt_valid  out  1   bank holds a complete checkpoint
//  ckpt_done   out  1   one-cycle pulse on checkpoint completion
//  rec_done    out  1   one-cycle pulse with pc_load
//  fatal       out  1   sticky; unrecoverable, cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, idx=1, retry=0, all outputs 0, restore_pc=0, ckpt_valid=0.
//  States: IDLE, CKPT, REST, LOADPC, FATAL (encoding in package).
//  IDLE:
//   - rec_req has priority over ckpt_req when both are high.
//   - On rec_req: if !ckpt_valid or retry==MAX_RETRY -> FATAL; else retry++, idx=1 -> REST.
//   - On ckpt_req: ckpt_valid<=0, pc_shadow<=core_pc, idx=1 -> CKPT.
//  CKPT (one register per cycle):
//   - rf_addr=idx, rr_A=idx, rr_WE=1.
//   - idx==NUM_REGS-1: next state IDLE; ckpt_valid<=1, retry<=0, restore_pc<=pc_shadow,
//     ckpt_done pulses in the first IDLE cycle.
//   - Busy for exactly NUM_REGS-1 (31) cycles.
//  rec_req during CKPT:
//   - Abort without writing that cycle; the bank is partial, so ckpt_valid stays 0.
//   - Next state FATAL.
//  REST:
//   - rr_A=idx, rf_addr=idx, rf_we=1; 31 cycles.
//   - After idx==NUM_REGS-1 -> LOADPC. rec_req ignored in REST and LOADPC.
//  LOADPC: pc_load=1, rec_done=1, restore_pc valid -> IDLE. Rollback latency 32 cycles.
//  FATAL: absorbing; fatal=1, stall=1, busy=1, all write enables 0.
//  Enables:
//   - rr_WE asserted only in CKPT; rf_we asserted only in REST. Never both.
//   - Address outputs are 0 when not in CKPT/REST.
//  Index: idx is a 5-bit counter and never wraps (max 31). x0 is never touched.
//  ckpt_req while busy is ignored, not queued. Requester holds it until ckpt_done.
//  Async reset mid-sequence: returns to reset values immediately. ckpt_valid=0 (bank contents untrusted).
// STRUCTURE
//  Package recovery_pkg:
//   - state enum
//   - REG_IDX_W=5
//   - localparam FIRST_REG=1
//  Sub-module recovery_ctr: idx counter with load/inc/last flag (last = idx==NUM_REGS-1).
//  FSM, retry counter and PC shadow stay in the top level.
// TESTING
//  1 Reset: after rst -> busy=0, ckpt_valid=0, fatal=0, rr_WE=rf_we=0.
//  2 Checkpoint: preload RF xi=0x100+i, core_pc=0x80, pulse ckpt_req.
//    -> 31 rr_WE cycles at A=1..31; bank[i]=0x100+i; ckpt_done once; ckpt_valid=1.
//  3 Rollback: after test 2, corrupt RF x5=0xDEAD, assert rec_req.
//    -> 31 rf_we cycles; x5=0x105; pc_load with restore_pc=0x80; rec_done; retry=1.
//  4 Retry limit: 4 rec_req with no checkpoint in between.
//    -> 3 rollbacks complete; 4th -> fatal=1, stall=1, no further writes.
//  5 Priority/abort: ckpt_req and rec_req same IDLE cycle -> REST chosen.
//    rec_req at CKPT idx=10 -> FATAL, ckpt_valid=0.
//  6 Reset mid-REST at idx=15 -> outputs 0 asynchronously; IDLE; ckpt_valid=0.
//    rec_req afterwards -> FATAL.

Source files
------------

// File: rtl/recovery_pkg.sv
// Shared types and constants for the checkpoint/rollback sequencer.
package recovery_pkg;

    // Width of an architectural register index (x0..x31).
    localparam int REG_IDX_W = 5;

    // x0 is hard-wired to zero, so copying starts at x1.
    localparam int FIRST_REG = 1;

    // Width of the recovery bank address bus.
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CKPT   = 3'd1,
        ST_REST   = 3'd2,
        ST_LOADPC = 3'd3,
        ST_FATAL  = 3'd4
    } state_e;

    // Zero-extend a register index onto the recovery bank address bus.
    function automatic logic [ADDR_W-1:0] idx_to_addr(input logic [REG_IDX_W-1:0] idx);
        return {{(ADDR_W-REG_IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/recovery_ctr.sv
// Register index counter shared by the checkpoint and restore walks.
// It reloads to the first copied register and saturates at the last one.
module recovery_ctr
    import recovery_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 inc,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 last
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(NUM_REGS - 1);

    logic [REG_IDX_W-1:0] idx_q;
    logic [REG_IDX_W-1:0] idx_d;

    // Next index: load wins over increment, and the count never wraps past the last register.
    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = FIRST_IDX;
        end else if (inc && (idx_q != LAST_IDX)) begin
            idx_d = idx_q + REG_IDX_W'(1);
        end
    end

    // Index register, parked on the first copied register out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= FIRST_IDX;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/recovery_sequencer.sv
// Checkpoint/rollback controller for the TMR core. Copies x1..x31 and the
// committed PC into the recovery bank on request, restores them into the main
// register file on a voter mismatch, and gives up after too many rollbacks.
module recovery_sequencer
    import recovery_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ckpt_req,
    input  logic                 rec_req,
    input  logic [31:0]          core_pc,
    output logic                 stall,
    output logic                 busy,
    output logic [REG_IDX_W-1:0] rf_addr,
    input  logic [31:0]          rf_rd,
    output logic                 rf_we,
    output logic [31:0]          rf_wd,
    output logic [ADDR_W-1:0]    rr_A,
    output logic                 rr_WE,
    output logic [31:0]          rr_WD,
    input  logic [31:0]          rr_RD,
    output logic                 pc_load,
    output logic [31:0]          restore_pc,
    output logic                 ckpt_valid,
    output logic                 ckpt_done,
    output logic                 rec_done,
    output logic                 fatal
);

    localparam int                 RETRY_W   = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_e               state_q, state_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [31:0]          pc_shadow_q, pc_shadow_d;
    logic [31:0]          restore_pc_q, restore_pc_d;
    logic                 ckpt_valid_q, ckpt_valid_d;
    logic                 ckpt_done_q, ckpt_done_d;

    logic                 ctr_load;
    logic                 ctr_inc;
    logic [REG_IDX_W-1:0] idx;
    logic                 idx_last;

    recovery_ctr #(
        .NUM_REGS (NUM_REGS)
    ) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (ctr_load),
        .inc  (ctr_inc),
        .idx  (idx),
        .last (idx_last)
    );

    // Next-state and Moore/Mealy outputs; everything defaults to the quiet IDLE values.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        pc_shadow_d  = pc_shadow_q;
        restore_pc_d = restore_pc_q;
        ckpt_valid_d = ckpt_valid_q;
        ckpt_done_d  = 1'b0;
        ctr_load     = 1'b0;
        ctr_inc      = 1'b0;
        busy         = 1'b0;
        fatal        = 1'b0;
        rf_addr      = '0;
        rr_A         = '0;
        rf_we        = 1'b0;
        rr_WE        = 1'b0;
        pc_load      = 1'b0;
        rec_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rec_req) begin
                    if (!ckpt_valid_q || (retry_q == RETRY_MAX)) begin
                        state_d = ST_FATAL;
                    end else begin
                        retry_d  = retry_q + RETRY_W'(1);
                        ctr_load = 1'b1;
                        state_d  = ST_REST;
                    end
                end else if (ckpt_req && !ckpt_done_q) begin
                    // The requester still holds ckpt_req in the done cycle, so that cycle must not start a second copy.
                    ckpt_valid_d = 1'b0;
                    pc_shadow_d  = core_pc;
                    ctr_load     = 1'b1;
                    state_d      = ST_CKPT;
                end
            end

            ST_CKPT: begin
                busy    = 1'b1;
                rf_addr = idx;
                rr_A    = idx_to_addr(idx);
                if (rec_req) begin
                    // Abort without writing; the bank is now partial and cannot be trusted.
                    state_d = ST_FATAL;
                end else begin
                    rr_WE = 1'b1;
                    if (idx_last) begin
                        ckpt_valid_d = 1'b1;
                        retry_d      = '0;
                        restore_pc_d = pc_shadow_q;
                        ckpt_done_d  = 1'b1;
                        ctr_load     = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
            end

            ST_REST: begin
                busy    = 1'b1;
                rf_addr = idx;
                rr_A    = idx_to_addr(idx);
                rf_we   = 1'b1;
                if (idx_last) begin
                    ctr_load = 1'b1;
                    state_d  = ST_LOADPC;
                end else begin
                    ctr_inc = 1'b1;
                end
            end

            ST_LOADPC: begin
                busy     = 1'b1;
                pc_load  = 1'b1;
                rec_done = 1'b1;
                state_d  = ST_IDLE;
            end

            ST_FATAL: begin
                busy  = 1'b1;
                fatal = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, retry count, PC shadow and checkpoint status; reset forgets any saved checkpoint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            retry_q      <= '0;
            pc_shadow_q  <= '0;
            restore_pc_q <= '0;
            ckpt_valid_q <= 1'b0;
            ckpt_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            pc_shadow_q  <= pc_shadow_d;
            restore_pc_q <= restore_pc_d;
            ckpt_valid_q <= ckpt_valid_d;
            ckpt_done_q  <= ckpt_done_d;
        end
    end

    // Data buses mirror the opposite file but read as zero whenever their write enable is low.
    assign rf_wd      = rf_we ? rr_RD : 32'd0;
    assign rr_WD      = rr_WE ? rf_rd : 32'd0;
    assign stall      = busy;
    assign restore_pc = restore_pc_q;
    assign ckpt_valid = ckpt_valid_q;
    assign ckpt_done  = ckpt_done_q;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Scoreboard bench for recovery_sequencer: a register-level model predicts the
// bank/RF write stream and pulses, and a negedge monitor checks them.
module tb_recovery_sequencer;
    import recovery_pkg::*;

    localparam int NREG      = 32;
    localparam int MAX_RETRY = 3;
    localparam int K_BANK    = 0;
    localparam int K_RF      = 1;
    localparam int K_PC      = 2;
    localparam int K_DONE    = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 ckpt_req = 1'b0;
    logic                 rec_req = 1'b0;
    logic [31:0]          core_pc = '0;
    logic                 stall, busy, rf_we, rr_WE, pc_load, ckpt_valid, ckpt_done, rec_done, fatal;
    logic [REG_IDX_W-1:0] rf_addr;
    logic [31:0]          rf_rd, rf_wd, rr_A, rr_WD, rr_RD, restore_pc;

    recovery_sequencer #(.NUM_REGS(NREG), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .ckpt_req(ckpt_req), .rec_req(rec_req), .core_pc(core_pc),
        .stall(stall), .busy(busy), .rf_addr(rf_addr), .rf_rd(rf_rd), .rf_we(rf_we),
        .rf_wd(rf_wd), .rr_A(rr_A), .rr_WE(rr_WE), .rr_WD(rr_WD), .rr_RD(rr_RD),
        .pc_load(pc_load), .restore_pc(restore_pc), .ckpt_valid(ckpt_valid),
        .ckpt_done(ckpt_done), .rec_done(rec_done), .fatal(fatal)
    );

    always #5 clk = ~clk;

    // Main register file and recovery bank, both with combinational reads.
    logic [31:0] rf_mem   [NREG];
    logic [31:0] bank_mem [NREG];
    assign rf_rd = rf_mem[rf_addr];
    assign rr_RD = bank_mem[rr_A[4:0]];

    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr] = rf_wd;
        if (rr_WE) bank_mem[rr_A[4:0]] = rr_WD;
    end

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    // Reference model: last completed checkpoint, retry count, fatal flag.
    logic [31:0] m_saved [NREG];
    logic [31:0] m_pc;
    bit          m_valid;
    int          m_retry;
    bit          m_fatal;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic popCheck(input int kind, input logic [31:0] addr, input logic [31:0] data, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: unexpected event addr 0x%08h data 0x%08h, expected none", name, addr, data);
        end else begin
            e = exp_q.pop_front();
            checkOutput({name, "_kind"}, 32'(kind), 32'(e.kind));
            checkOutput({name, "_addr"}, addr, e.addr);
            checkOutput({name, "_data"}, data, e.data);
        end
    endtask

    // Monitor: every write or pulse the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rr_WE || rf_we) checkOutput("we_exclusive", {31'd0, rr_WE & rf_we}, 32'd0);
            if (rr_WE) popCheck(K_BANK, rr_A, rr_WD, "bank_write");
            if (rf_we) popCheck(K_RF, {27'd0, rf_addr}, rf_wd, "rf_write");
            if (pc_load || rec_done) begin
                checkOutput("rec_done_pair", {31'd0, rec_done}, {31'd0, pc_load});
                popCheck(K_PC, 32'd0, restore_pc, "pc_load");
            end
            if (ckpt_done) popCheck(K_DONE, 32'd0, 32'd0, "ckpt_done");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit ck, input bit rc);
        ckpt_req = ck;
        rec_req  = rc;
        tick();
        ckpt_req = 1'b0;
        rec_req  = 1'b0;
    endtask

    task automatic waitIdle(input int limit, output int cycles);
        cycles = 0;
        while (busy && !fatal && cycles < limit) begin
            cycles++;
            tick();
        end
        if (busy && !fatal) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", cycles);
        end
    endtask

    task automatic doReset();
        rst      = 1'b1;
        ckpt_req = 1'b0;
        rec_req  = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        m_valid = 1'b0;
        m_retry = 0;
        m_fatal = 1'b0;
    endtask

    task automatic checkFatal(input string name);
        checkOutput({name, "_fatal"}, {31'd0, fatal}, 32'd1);
        checkOutput({name, "_stall"}, {31'd0, stall}, 32'd1);
        checkOutput({name, "_busy"},  {31'd0, busy},  32'd1);
    endtask

    // One request, with the outcome predicted from the model's checkpoint/retry rules.
    task automatic doOp(input bit ck, input bit rc, input logic [31:0] pc);
        int cyc;
        core_pc = pc;
        if (m_fatal) begin
            applyStimulus(ck, rc);
            repeat (4) tick();
            checkFatal("fatal_sticky");
        end else if (rc) begin
            if (!m_valid || m_retry == MAX_RETRY) begin
                applyStimulus(ck, rc);
                repeat (4) tick();
                checkFatal("fatal_enter");
                m_fatal = 1'b1;
            end else begin
                for (int i = 1; i < NREG; i++) exp_q.push_back('{K_RF, 32'(i), m_saved[i]});
                exp_q.push_back('{K_PC, 32'd0, m_pc});
                applyStimulus(ck, rc);
                waitIdle(40, cyc);
                checkOutput("rollback_cycles", 32'(cyc), 32'd32);
                settle();
                checkOutput("rollback_drain", 32'(exp_q.size()), 32'd0);
                for (int i = 1; i < NREG; i++) checkOutput("rf_restored", rf_mem[i], m_saved[i]);
                m_retry++;
            end
        end else if (ck) begin
            for (int i = 1; i < NREG; i++) exp_q.push_back('{K_BANK, 32'(i), rf_mem[i]});
            exp_q.push_back('{K_DONE, 32'd0, 32'd0});
            for (int i = 0; i < NREG; i++) m_saved[i] = rf_mem[i];
            m_pc = pc;
            applyStimulus(ck, rc);
            waitIdle(40, cyc);
            checkOutput("ckpt_cycles", 32'(cyc), 32'd31);
            settle();
            checkOutput("ckpt_drain", 32'(exp_q.size()), 32'd0);
            checkOutput("ckpt_valid", {31'd0, ckpt_valid}, 32'd1);
            checkOutput("ckpt_restore_pc", restore_pc, pc);
            m_valid = 1'b1;
            m_retry = 0;
        end
        tick();
    endtask

    // Start a checkpoint, then raise rec_req while the walk is on register abort_idx.
    task automatic doAbort(input logic [31:0] pc, input int abort_idx);
        for (int i = 1; i < abort_idx; i++) exp_q.push_back('{K_BANK, 32'(i), rf_mem[i]});
        core_pc = pc;
        applyStimulus(1'b1, 1'b0);
        repeat (abort_idx - 1) tick();
        applyStimulus(1'b0, 1'b1);
        settle();
        checkOutput("abort_drain", 32'(exp_q.size()), 32'd0);
        checkOutput("abort_ckpt_valid", {31'd0, ckpt_valid}, 32'd0);
        checkFatal("abort");
        m_valid = 1'b0;
        m_fatal = 1'b1;
        tick();
    endtask

    // Start a rollback and hit reset while the walk is on register rst_idx.
    task automatic resetDuringRollback(input int rst_idx);
        for (int i = 1; i < rst_idx; i++) exp_q.push_back('{K_RF, 32'(i), m_saved[i]});
        applyStimulus(1'b0, 1'b1);
        repeat (rst_idx - 1) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_drain", 32'(exp_q.size()), 32'd0);
        checkOutput("midrst_busy",  {31'd0, busy},  32'd0);
        checkOutput("midrst_stall", {31'd0, stall}, 32'd0);
        checkOutput("midrst_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("midrst_rf_addr", {27'd0, rf_addr}, 32'd0);
        checkOutput("midrst_rr_A", rr_A, 32'd0);
        checkOutput("midrst_ckpt_valid", {31'd0, ckpt_valid}, 32'd0);
        checkOutput("midrst_restore_pc", restore_pc, 32'd0);
        exp_q.delete();
        #3 rst = 1'b0;
        tick();
        m_valid = 1'b0;
        m_retry = 0;
        m_fatal = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rf_mem[i]   = 32'hA5A5_0000;
            bank_mem[i] = 32'h5A5A_0000;
        end

        // Reset state
        doReset();
        checkOutput("reset_busy",       {31'd0, busy},       32'd0);
        checkOutput("reset_stall",      {31'd0, stall},      32'd0);
        checkOutput("reset_ckpt_valid", {31'd0, ckpt_valid}, 32'd0);
        checkOutput("reset_fatal",      {31'd0, fatal},      32'd0);
        checkOutput("reset_rr_WE",      {31'd0, rr_WE},      32'd0);
        checkOutput("reset_rf_we",      {31'd0, rf_we},      32'd0);
        checkOutput("reset_restore_pc", restore_pc,          32'd0);

        // Checkpoint of a known register pattern
        for (int i = 1; i < NREG; i++) rf_mem[i] = 32'h100 + 32'(i);
        doOp(1'b1, 1'b0, 32'h80);
        checkOutput("bank_x31", bank_mem[31], 32'h11F);

        // Rollback repairs a corrupted register and reloads the PC
        rf_mem[5] = 32'hDEAD;
        doOp(1'b0, 1'b1, 32'h0);
        checkOutput("rollback_x5", rf_mem[5], 32'h105);
        checkOutput("rollback_pc", restore_pc, 32'h80);

        // Retry limit: two more rollbacks succeed, the fourth is fatal and sticky
        doOp(1'b0, 1'b1, 32'h0);
        doOp(1'b0, 1'b1, 32'h0);
        doOp(1'b0, 1'b1, 32'h0);
        doOp(1'b1, 1'b0, 32'h444);

        // Priority of rec_req over ckpt_req, then abort of a checkpoint at x10
        doReset();
        for (int i = 1; i < NREG; i++) rf_mem[i] = $urandom;
        doOp(1'b1, 1'b0, 32'h200);
        doOp(1'b1, 1'b1, 32'h999);
        checkOutput("priority_pc", restore_pc, 32'h200);
        doAbort(32'h300, 10);

        // Reset in the middle of a rollback, after which nothing is trusted
        doReset();
        for (int i = 1; i < NREG; i++) rf_mem[i] = $urandom;
        doOp(1'b1, 1'b0, 32'h300);
        resetDuringRollback(15);
        doOp(1'b0, 1'b1, 32'h0);

        // Randomized request sequences
        for (int ep = 0; ep < 4; ep++) begin
            doReset();
            for (int n = 0; n < 10 && !m_fatal; n++) begin
                int op;
                op = (n == 0) ? 0 : int'($urandom_range(0, 3));
                case (op)
                    0, 1: begin
                        for (int i = 1; i < NREG; i++) rf_mem[i] = $urandom;
                        doOp(1'b1, 1'b0, $urandom);
                    end
                    2: begin
                        rf_mem[$urandom_range(1, NREG - 1)] = $urandom;
                        doOp(1'b0, 1'b1, 32'h0);
                    end
                    default: begin
                        doOp(1'b1, 1'b1, $urandom);
                    end
                endcase
            end
        end

        checkOutput("x0_rf_untouched",   rf_mem[0],   32'hA5A5_0000);
        checkOutput("x0_bank_untouched", bank_mem[0], 32'h5A5A_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
